// File: rtl/vga_timing_rx.sv
// VGA stream receiver: measures line/frame geometry, locks onto stable timing
// and re-emits active pixels with recovered x/y coordinates.
`timescale 1ns/1ps
module vga_timing_rx #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic             vga_href,
  input  logic [23:0]      vga_rgb,
  output logic             pix_valid,
  output logic [23:0]      pix_data,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             frame_start,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] meas_h_total,
  output logic [CNT_W-1:0] meas_h_disp,
  output logic [CNT_W-1:0] meas_v_total,
  output logic [CNT_W-1:0] meas_v_disp
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, href_s1_q;
  logic [23:0] rgb_s1_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1_q   <= 1'b0;
      hs_s2_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      href_s1_q <= 1'b0;
      rgb_s1_q  <= '0;
    end else begin
      hs_s1_q   <= vga_hs;
      hs_s2_q   <= hs_s1_q;
      vs_s1_q   <= vga_vs;
      vs_s2_q   <= vs_s1_q;
      href_s1_q <= vga_href;
      rgb_s1_q  <= vga_rgb;
    end
  end

  logic             hs_fall, vs_fall, sat;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, act_cnt_q, act_cnt_d, act_base;
  logic [CNT_W-1:0] v_lines_q, v_lines_d, v_act_q, v_act_d;
  logic [CNT_W-1:0] line_total;
  logic             line_ok_q, line_end, line_act, line_bad, v_bad;

  state_e           state_q;
  logic [CNT_W-1:0] ref_h_total_q, ref_h_disp_q, ref_v_total_q, ref_v_disp_q;
  logic             have_h_q, have_d_q, frame_bad_q, err_q;
  logic [3:0]       match_q;

  assign hs_fall    = hs_s2_q & ~hs_s1_q;
  assign vs_fall    = vs_s2_q & ~vs_s1_q;
  assign sat        = (h_cnt_q == CNT_MAX);
  assign line_total = h_cnt_q + CNT_ONE;
  assign line_act   = (act_cnt_q != '0);
  // Only lines opened after the last entry to MEASURE are trusted for checks.
  assign line_end   = hs_fall & line_ok_q;
  assign line_bad   = line_end & ((line_total != ref_h_total_q) |
                                  (line_act & (act_cnt_q != ref_h_disp_q)));
  assign v_bad      = (v_lines_q != ref_v_total_q) | (v_act_q != ref_v_disp_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q;
    if (hs_fall)   h_cnt_d = '0;
    else if (!sat) h_cnt_d = h_cnt_q + CNT_ONE;

    act_base  = hs_fall ? '0 : act_cnt_q;
    act_cnt_d = act_base + CNT_W'(href_s1_q);

    v_lines_d = v_lines_q;
    if (hs_fall) v_lines_d = v_lines_q + CNT_ONE;
    if (vs_fall) v_lines_d = hs_fall ? CNT_ONE : '0;

    v_act_d = v_act_q;
    if (hs_fall && line_act) v_act_d = v_act_q + CNT_ONE;
    if (vs_fall)             v_act_d = '0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q   <= '0;
      act_cnt_q <= '0;
      v_lines_q <= '0;
      v_act_q   <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      act_cnt_q <= act_cnt_d;
      v_lines_q <= v_lines_d;
      v_act_q   <= v_act_d;
    end
  end

  logic to_measure;

  always_comb begin
    to_measure = 1'b0;
    if (!sat) begin
      case (state_q)
        SEARCH:  to_measure = vs_fall;
        VERIFY:  to_measure = vs_fall & (frame_bad_q | line_bad | v_bad);
        LOCKED:  to_measure = line_bad | (vs_fall & v_bad);
        default: to_measure = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      ref_h_total_q <= '0;
      ref_h_disp_q  <= '0;
      ref_v_total_q <= '0;
      ref_v_disp_q  <= '0;
      have_h_q      <= 1'b0;
      have_d_q      <= 1'b0;
      line_ok_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      match_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (hs_fall) line_ok_q <= 1'b1;
      if (sat) begin
        state_q   <= SEARCH;
        line_ok_q <= 1'b0;
        err_q     <= (state_q == LOCKED);
      end else begin
        case (state_q)
          SEARCH: if (vs_fall) state_q <= MEASURE;
          MEASURE: begin
            if (line_end) begin
              if (!have_h_q || line_total != ref_h_total_q) begin
                ref_h_total_q <= line_total;
                have_h_q      <= 1'b1;
              end
              if (line_act && (!have_d_q || act_cnt_q != ref_h_disp_q)) begin
                ref_h_disp_q <= act_cnt_q;
                have_d_q     <= 1'b1;
              end
            end
            if (vs_fall) begin
              ref_v_total_q <= v_lines_q;
              ref_v_disp_q  <= v_act_q;
              match_q       <= '0;
              frame_bad_q   <= 1'b0;
              state_q       <= VERIFY;
            end
          end
          VERIFY: begin
            if (vs_fall) begin
              frame_bad_q <= 1'b0;
              if (to_measure) begin
                state_q       <= MEASURE;
                ref_v_total_q <= v_lines_q;
                ref_v_disp_q  <= v_act_q;
              end else begin
                match_q <= match_q + 4'd1;
                if (match_q + 4'd1 == LOCK_N) state_q <= LOCKED;
              end
            end else if (line_bad) begin
              frame_bad_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (to_measure) begin
              state_q <= MEASURE;
              err_q   <= 1'b1;
              if (vs_fall) begin
                ref_v_total_q <= v_lines_q;
                ref_v_disp_q  <= v_act_q;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
        if (to_measure) begin
          line_ok_q <= hs_fall;
          have_h_q  <= 1'b0;
          have_d_q  <= 1'b0;
        end
      end
    end
  end

  logic             pix_ok;
  logic             pix_valid_q, frame_start_q;
  logic [23:0]      pix_data_q;
  logic [CNT_W-1:0] x_q, y_q;

  assign pix_ok = (state_q == LOCKED) & href_s1_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_valid_q   <= pix_ok;
      pix_data_q    <= pix_ok ? rgb_s1_q : '0;
      frame_start_q <= vs_fall;
      if (pix_ok) begin
        x_q <= act_base;
        y_q <= v_act_d;
      end
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign frame_start  = frame_start_q;
  assign locked       = (state_q == LOCKED);
  assign err_pulse    = err_q;
  assign meas_h_total = ref_h_total_q;
  assign meas_h_disp  = ref_h_disp_q;
  assign meas_v_total = ref_v_total_q;
  assign meas_v_disp  = ref_v_disp_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx on a scaled-down raster (40/16 clocks, 20/12 lines)
// with coincident hs/vs edges; a second instance runs with LOCK_FRAMES=1.
`timescale 1ns/1ps
module tb_vga_timing_rx;

  localparam int HT = 40, HD = 16, HA = 10, HSW = 4;
  localparam int VT = 20, VD = 12, VA = 4, VSW = 2;
  localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h0};

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        vga_hs, vga_vs, vga_href;
  logic [23:0] vga_rgb;

  logic        pix_valid, frame_start, locked, err_pulse;
  logic [23:0] pix_data;
  logic [11:0] x_pos, y_pos, meas_h_total, meas_h_disp, meas_v_total, meas_v_disp;

  logic        pix_valid1, frame_start1, locked1, err_pulse1;
  logic [23:0] pix_data1;
  logic [11:0] x_pos1, y_pos1, meas_h_total1, meas_h_disp1, meas_v_total1, meas_v_disp1;

  vga_timing_rx dut (
    .clk_in(clk_in), .rst_n(rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_href(vga_href), .vga_rgb(vga_rgb), .pix_valid(pix_valid), .pix_data(pix_data),
    .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start), .locked(locked),
    .err_pulse(err_pulse), .meas_h_total(meas_h_total), .meas_h_disp(meas_h_disp),
    .meas_v_total(meas_v_total), .meas_v_disp(meas_v_disp)
  );

  vga_timing_rx #(.LOCK_FRAMES(1)) dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_href(vga_href), .vga_rgb(vga_rgb), .pix_valid(pix_valid1), .pix_data(pix_data1),
    .x_pos(x_pos1), .y_pos(y_pos1), .frame_start(frame_start1), .locked(locked1),
    .err_pulse(err_pulse1), .meas_h_total(meas_h_total1), .meas_h_disp(meas_h_disp1),
    .meas_v_total(meas_v_total1), .meas_v_disp(meas_v_disp1)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  int          cyc, pv_cnt, data_bad, err_cnt, err_at, fs_cnt, lock_rise_fs, fs1_cnt;
  logic        lock_rise_on_fs, locked_prev, lock1_seen;
  logic [11:0] first_x, first_y, last_x, last_y;
  logic [11:0] mvt1 [8];
  logic [23:0] rgb_h1, rgb_h2;

  function automatic logic [26:0] pix_at(int l, int x);
    logic hs, vs, hr;
    logic [23:0] rgb;
    hs  = !(x < HSW);
    vs  = !(l < VSW);
    hr  = (l >= VA) && (l < VA + VD) && (x >= HA) && (x < HA + HD);
    rgb = {l[7:0], x[7:0], 8'hA5 ^ l[7:0]};
    return {hs, vs, hr, rgb};
  endfunction

  task automatic clear_obs();
    cyc = 0; pv_cnt = 0; data_bad = 0; err_cnt = 0; err_at = -1;
    fs_cnt = 0; lock_rise_fs = -1; lock_rise_on_fs = 1'b0; fs1_cnt = 0; lock1_seen = 1'b0;
    first_x = '1; first_y = '1; last_x = '1; last_y = '1;
    for (int i = 0; i < 8; i++) mvt1[i] = '1;
  endtask

  // One pixel clock: observe outputs at the falling edge, then drive the next input.
  task automatic step(input logic [26:0] v);
    @(negedge clk_in);
    cyc++;
    if (pix_valid) begin
      if (pv_cnt == 0) begin first_x = x_pos; first_y = y_pos; end
      last_x = x_pos; last_y = y_pos; pv_cnt++;
      if (pix_data !== rgb_h2) data_bad++;
    end else if (pix_data !== 24'h0) begin
      data_bad++;
    end
    if (err_pulse) begin err_cnt++; err_at = cyc; end
    if (frame_start) fs_cnt++;
    if (locked && !locked_prev) begin lock_rise_fs = fs_cnt; lock_rise_on_fs = frame_start; end
    locked_prev = locked;
    if (locked1) lock1_seen = 1'b1;
    if (frame_start1) begin
      if (fs1_cnt < 8) mvt1[fs1_cnt] = meas_v_total1;
      fs1_cnt++;
    end
    rgb_h2 = rgb_h1;
    rgb_h1 = v[23:0];
    {vga_hs, vga_vs, vga_href, vga_rgb} = v;
  endtask

  task automatic gen_frame(input int vt, input int short_line);
    for (int l = 0; l < vt; l++) begin
      for (int x = 0; x < ((l == short_line) ? HT - 1 : HT); x++) step(pix_at(l, x));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {vga_hs, vga_vs, vga_href, vga_rgb} = IDLE;
    rgb_h1 = '0; rgb_h2 = '0; locked_prev = 1'b0;
    repeat (3) @(negedge clk_in);
    vectors++;
    if ({pix_valid, frame_start, locked, err_pulse} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags got %b want 0000", {pix_valid, frame_start, locked, err_pulse});
    end
    vectors++;
    if ({pix_data, x_pos, y_pos} !== 48'h0) begin
      miscompares++; $display("FAIL reset_pixel got %h/%0d/%0d want 0/0/0", pix_data, x_pos, y_pos);
    end
    vectors++;
    if ({meas_h_total, meas_h_disp, meas_v_total, meas_v_disp} !== 48'h0) begin
      miscompares++; $display("FAIL reset_meas got %0d/%0d/%0d/%0d want 0/0/0/0",
                              meas_h_total, meas_h_disp, meas_v_total, meas_v_disp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    clear_obs();
    repeat (4) gen_frame(VT, -1);
    vectors++;
    if (lock_rise_fs !== 4 || lock_rise_on_fs !== 1'b1) begin
      miscompares++; $display("FAIL lock_timing got rise at frame_start %0d (coincident=%b) want 4 (1)",
                              lock_rise_fs, lock_rise_on_fs);
    end
    vectors++;
    if ({meas_h_total, meas_h_disp, meas_v_total, meas_v_disp} !== {12'd40, 12'd16, 12'd20, 12'd12}) begin
      miscompares++; $display("FAIL lock_meas got %0d/%0d/%0d/%0d want 40/16/20/12",
                              meas_h_total, meas_h_disp, meas_v_total, meas_v_disp);
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++; $display("FAIL lock_err got %0d pulses want 0", err_cnt);
    end
  endtask

  task automatic test_sweep();
    clear_obs();
    gen_frame(VT, -1);
    vectors++;
    if (pv_cnt !== HD * VD) begin
      miscompares++; $display("FAIL sweep_count got %0d want %0d", pv_cnt, HD * VD);
    end
    vectors++;
    if (first_x !== 12'd0 || first_y !== 12'd0) begin
      miscompares++; $display("FAIL sweep_first got x=%0d y=%0d want x=0 y=0", first_x, first_y);
    end
    vectors++;
    if (last_x !== 12'd15 || last_y !== 12'd11) begin
      miscompares++; $display("FAIL sweep_last got x=%0d y=%0d want x=15 y=11", last_x, last_y);
    end
    vectors++;
    if (data_bad !== 0 || err_cnt !== 0) begin
      miscompares++; $display("FAIL sweep_data got %0d bad pixels, %0d errs want 0, 0", data_bad, err_cnt);
    end
  endtask

  task automatic test_short_line();
    clear_obs();
    gen_frame(VT, 2);
    vectors++;
    if (err_cnt !== 1) begin
      miscompares++; $display("FAIL short_err got %0d pulses want 1", err_cnt);
    end
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++; $display("FAIL short_unlock got locked=%b want 0", locked);
    end
    clear_obs();
    repeat (3) gen_frame(VT, -1);
    vectors++;
    if (lock_rise_fs !== 3 || lock_rise_on_fs !== 1'b1 || err_cnt !== 0) begin
      miscompares++; $display("FAIL short_relock got rise at %0d (coincident=%b, errs=%0d) want 3 (1, 0)",
                              lock_rise_fs, lock_rise_on_fs, err_cnt);
    end
    vectors++;
    if (meas_h_total !== 12'd40 || meas_h_disp !== 12'd16) begin
      miscompares++; $display("FAIL short_meas got %0d/%0d want 40/16", meas_h_total, meas_h_disp);
    end
  endtask

  task automatic test_midline_reset();
    clear_obs();
    for (int l = 0; l < 8; l++)
      for (int x = 0; x < HT; x++) step(pix_at(l, x));
    for (int x = 0; x < 20; x++) step(pix_at(8, x));
    vectors++;
    if (locked !== 1'b1 || pix_valid !== 1'b1) begin
      miscompares++; $display("FAIL midrst_pre got locked=%b pix_valid=%b want 1/1", locked, pix_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pix_valid, pix_data, x_pos, y_pos, frame_start, locked, err_pulse,
         meas_h_total, meas_h_disp, meas_v_total, meas_v_disp} !== 124'h0) begin
      miscompares++; $display("FAIL midrst_outputs got pv=%b data=%h x=%0d y=%0d lk=%b mh=%0d mv=%0d want all 0",
                              pix_valid, pix_data, x_pos, y_pos, locked, meas_h_total, meas_v_total);
    end
    repeat (3) step(IDLE);
    rst_n = 1'b1;
    clear_obs();
    repeat (4) gen_frame(VT, -1);
    vectors++;
    if (lock_rise_fs !== 4 || lock_rise_on_fs !== 1'b1 || err_cnt !== 0) begin
      miscompares++; $display("FAIL midrst_relock got rise at %0d (coincident=%b, errs=%0d) want 4 (1, 0)",
                              lock_rise_fs, lock_rise_on_fs, err_cnt);
    end
    vectors++;
    if ({meas_h_total, meas_h_disp, meas_v_total, meas_v_disp} !== {12'd40, 12'd16, 12'd20, 12'd12}) begin
      miscompares++; $display("FAIL midrst_meas got %0d/%0d/%0d/%0d want 40/16/20/12",
                              meas_h_total, meas_h_disp, meas_v_total, meas_v_disp);
    end
  endtask

  // Last hs falls 40 clocks before the hold starts; saturation is seen 4058 hold cycles later.
  task automatic test_sync_loss();
    clear_obs();
    for (int i = 0; i < 4300; i++) step(IDLE);
    vectors++;
    if (err_cnt !== 1 || err_at !== 4059) begin
      miscompares++; $display("FAIL sync_err got %0d pulses at cycle %0d want 1 at 4059", err_cnt, err_at);
    end
    vectors++;
    if (locked !== 1'b0 || pv_cnt !== 0) begin
      miscompares++; $display("FAIL sync_state got locked=%b pix_valid_cycles=%0d want 0/0", locked, pv_cnt);
    end
  endtask

  task automatic test_lock_frames_one();
    rst_n = 1'b0;
    repeat (2) step(IDLE);
    rst_n = 1'b1;
    clear_obs();
    for (int f = 0; f < 6; f++) gen_frame((f % 2 == 0) ? VT : VT - 1, -1);
    vectors++;
    if (lock1_seen !== 1'b0 || fs1_cnt !== 6) begin
      miscompares++; $display("FAIL lf1_nolock got locked_seen=%b frame_starts=%0d want 0/6", lock1_seen, fs1_cnt);
    end
    vectors++;
    if (mvt1[0] !== 12'd0 || mvt1[1] !== 12'd20 || mvt1[2] !== 12'd19 ||
        mvt1[3] !== 12'd20 || mvt1[4] !== 12'd19 || mvt1[5] !== 12'd20) begin
      miscompares++; $display("FAIL lf1_vtotal got %0d %0d %0d %0d %0d %0d want 0 20 19 20 19 20",
                              mvt1[0], mvt1[1], mvt1[2], mvt1[3], mvt1[4], mvt1[5]);
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_lock();
    test_sweep();
    test_short_line();
    test_midline_reset();
    test_sync_loss();
    test_lock_frames_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got time limit reached want run to complete");
    $fatal(1, "watchdog");
  end

endmodule
